// File: rtl/phase_interval_meter_pkg.sv
// Shared types and constants for the REF-to-Inp phase interval meter.
// The state encoding is fixed so that debug probes can decode it directly.
package phase_interval_meter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int EDGE_SEL_REF = 0;
   localparam int EDGE_SEL_INP = 1;

endpackage

// File: rtl/phase_interval_meter_sync_edge_det.sv
// Metastability synchroniser followed by a one-cycle edge detector.
// REF and Inp each get an identical copy, so their latencies match exactly.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   input  logic fall_sel,
   output logic edge_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   syncOut;

   assign syncOut = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= syncOut;
      end
   end

   assign edge_pulse = fall_sel ? (hist_q & ~syncOut) : (syncOut & ~hist_q);

endmodule

// File: rtl/phase_interval_meter.sv
// Measures clk cycles from a selected REF edge to the next selected Inp edge,
// with single-shot or continuous operation and a saturating result.
module phase_interval_meter
   import phase_interval_meter_pkg::*;
#(
   parameter int W           = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         st,
   input  logic         mode,
   input  logic [1:0]   edge_sel,
   input  logic         REF,
   input  logic         Inp,
   output logic [W-1:0] Q,
   output logic         valid,
   output logic         ovf,
   output logic         busy
);

   localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
   localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

   state_e         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]   q_q, q_d;
   logic           ovf_q, ovf_d;
   logic [W-1:0]   cntInc;
   logic           refEdge;
   logic           inpEdge;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) uRefDet (
      .clk        (clk),
      .rst        (rst),
      .async_in   (REF),
      .fall_sel   (edge_sel[EDGE_SEL_REF]),
      .edge_pulse (refEdge)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) uInpDet (
      .clk        (clk),
      .rst        (rst),
      .async_in   (Inp),
      .fall_sel   (edge_sel[EDGE_SEL_INP]),
      .edge_pulse (inpEdge)
   );

   assign cntInc = cnt_q + ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
      end
   end

   // The result is captured on entry to DONE so Q is already current while valid is high;
   // cnt_q lags the REF pulse by one cycle, hence cntInc is the true interval.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (st) begin
               state_d = ARM;
            end
         end
         ARM: begin
            cnt_d = '0;
            if (refEdge && inpEdge) begin
               q_d     = '0;
               ovf_d   = 1'b0;
               state_d = DONE;
            end else if (refEdge) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            cnt_d = cntInc;
            if (inpEdge) begin
               q_d     = cntInc;
               ovf_d   = 1'b0;
               state_d = DONE;
            end else if (cntInc == ALL_ONES) begin
               q_d     = ALL_ONES;
               ovf_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = mode ? ARM : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Q     = q_q;
   assign ovf   = ovf_q;
   assign valid = (state_q == DONE);
   assign busy  = (state_q == ARM) || (state_q == COUNT);

endmodule
